// File: rtl/pipe_pkg.sv
// Shared types for the decode-to-execute pipeline register.
// Holds the occupancy state encoding and the hardwired-zero register number.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready entry bundle between pipeline stages.
// master drives valid + entry fields and reads ready; slave is the mirror.
interface pipe_stage_reg_if #(
  parameter int PAYLOAD_W = 128,
  parameter int SIDE_W    = 8,
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5
);
  logic                 valid;
  logic                 ready;
  logic [PAYLOAD_W-1:0] payload;
  logic [SIDE_W-1:0]    side;
  logic                 kill;
  logic [REG_AW-1:0]    rs;
  logic [REG_AW-1:0]    rt;
  logic [XLEN-1:0]      bus_a;
  logic [XLEN-1:0]      bus_b;

  modport master (
    output valid, payload, side, kill,
    output rs, rt, bus_a, bus_b,
    input  ready
  );

  modport slave (
    input  valid, payload, side, kill,
    input  rs, rt, bus_a, bus_b,
    output ready
  );
endinterface

// File: rtl/fwd_mux.sv
// Priority bypass for one operand: lowest-index matching producer wins.
// Ports: rnum/dflt = source reg and regfile value; fwd_* = producers; val = result.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int N_FWD  = 3
) (
  input  logic [REG_AW-1:0]       rnum,
  input  logic [XLEN-1:0]         dflt,
  input  logic [N_FWD-1:0]        fwd_valid,
  input  logic [N_FWD*REG_AW-1:0] fwd_wnum,
  input  logic [N_FWD*XLEN-1:0]   fwd_data,
  output logic [XLEN-1:0]         val
);

  // Scan oldest to youngest so the youngest match overwrites last.
  always_comb begin
    val = dflt;
    for (int i = N_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] &&
          fwd_wnum[i*REG_AW +: REG_AW] == rnum &&
          rnum != REG_AW'(REG_ZERO))
        val = fwd_data[i*XLEN +: XLEN];
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Decode-to-execute register: 2-entry skid, operand bypass, kill, flush.
// Ports: clk, rst (sync, active-low); up (slave) from decode; dn (master)
// to execute; fwd_valid/fwd_wnum/fwd_data producers; flush.
// Build option PIPE_FWD_REFRESH_EN: held entries re-bypass every cycle.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 128,
  parameter int SIDE_W    = 8,
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int N_FWD     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  pipe_stage_reg_if.slave         up,
  pipe_stage_reg_if.master        dn,
  input  logic [N_FWD-1:0]        fwd_valid,
  input  logic [N_FWD*REG_AW-1:0] fwd_wnum,
  input  logic [N_FWD*XLEN-1:0]   fwd_data,
  input  logic                    flush
);

`ifdef PIPE_FWD_REFRESH_EN
  localparam int RW = 2 * REG_AW;
`else
  localparam int RW = 0;
`endif

  // Entry layout: {[rt, rs], killed, side, payload, b, a}
  localparam int A_LO  = 0;
  localparam int B_LO  = XLEN;
  localparam int P_LO  = 2 * XLEN;
  localparam int S_LO  = P_LO + PAYLOAD_W;
  localparam int K_BIT = S_LO + SIDE_W;
  localparam int E_W   = K_BIT + 1 + RW;

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic [E_W-1:0]  hd_q, hd_d, sk_q, sk_d;
  logic [E_W-1:0]  hd_cur, sk_cur, cap_e;
  logic [XLEN-1:0] cap_a, cap_b;
  logic            acc, pop;

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .N_FWD(N_FWD)) u_cap_a (
    .rnum(up.rs), .dflt(up.bus_a),
    .fwd_valid(fwd_valid), .fwd_wnum(fwd_wnum),
    .fwd_data(fwd_data), .val(cap_a)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .N_FWD(N_FWD)) u_cap_b (
    .rnum(up.rt), .dflt(up.bus_b),
    .fwd_valid(fwd_valid), .fwd_wnum(fwd_wnum),
    .fwd_data(fwd_data), .val(cap_b)
  );

`ifdef PIPE_FWD_REFRESH_EN
  localparam int RS_LO = K_BIT + 1;
  localparam int RT_LO = RS_LO + REG_AW;

  logic [XLEN-1:0] hd_ra, hd_rb, sk_ra, sk_rb;

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .N_FWD(N_FWD)) u_hd_a (
    .rnum(hd_q[RS_LO +: REG_AW]), .dflt(hd_q[A_LO +: XLEN]),
    .fwd_valid(fwd_valid), .fwd_wnum(fwd_wnum),
    .fwd_data(fwd_data), .val(hd_ra)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .N_FWD(N_FWD)) u_hd_b (
    .rnum(hd_q[RT_LO +: REG_AW]), .dflt(hd_q[B_LO +: XLEN]),
    .fwd_valid(fwd_valid), .fwd_wnum(fwd_wnum),
    .fwd_data(fwd_data), .val(hd_rb)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .N_FWD(N_FWD)) u_sk_a (
    .rnum(sk_q[RS_LO +: REG_AW]), .dflt(sk_q[A_LO +: XLEN]),
    .fwd_valid(fwd_valid), .fwd_wnum(fwd_wnum),
    .fwd_data(fwd_data), .val(sk_ra)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .N_FWD(N_FWD)) u_sk_b (
    .rnum(sk_q[RT_LO +: REG_AW]), .dflt(sk_q[B_LO +: XLEN]),
    .fwd_valid(fwd_valid), .fwd_wnum(fwd_wnum),
    .fwd_data(fwd_data), .val(sk_rb)
  );

  always_comb begin
    hd_cur = hd_q;
    sk_cur = sk_q;
    hd_cur[A_LO +: XLEN] = hd_ra;
    hd_cur[B_LO +: XLEN] = hd_rb;
    sk_cur[A_LO +: XLEN] = sk_ra;
    sk_cur[B_LO +: XLEN] = sk_rb;
  end

  assign cap_e = {up.rt, up.rs, up.kill,
                  up.kill ? {SIDE_W{1'b0}} : up.side,
                  up.payload, cap_b, cap_a};
  assign dn.rs = hd_q[RS_LO +: REG_AW];
  assign dn.rt = hd_q[RT_LO +: REG_AW];
`else
  assign hd_cur = hd_q;
  assign sk_cur = sk_q;
  assign cap_e  = {up.kill,
                   up.kill ? {SIDE_W{1'b0}} : up.side,
                   up.payload, cap_b, cap_a};
  assign dn.rs  = '0;
  assign dn.rt  = '0;
`endif

  assign acc = up.valid & in_ready_q;
  assign pop = (state_q != EMPTY) & dn.ready;

  always_comb begin
    state_d = state_q;
    hd_d    = hd_cur;
    sk_d    = sk_cur;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          hd_d    = cap_e;
          state_d = ONE;
        end
      end
      ONE: begin
        if (acc && pop) begin
          hd_d = cap_e;
        end else if (acc) begin
          sk_d    = cap_e;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          hd_d    = sk_cur;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over both pop and a same-cycle accept.
    if (flush) state_d = EMPTY;
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      hd_q       <= '0;
      sk_q       <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      hd_q       <= hd_d;
      sk_q       <= sk_d;
    end
  end

  assign up.ready   = in_ready_q;
  assign dn.valid   = (state_q != EMPTY);
  assign dn.payload = hd_q[P_LO +: PAYLOAD_W];
  assign dn.side    = hd_q[S_LO +: SIDE_W];
  assign dn.kill    = hd_q[K_BIT];
  assign dn.bus_a   = hd_q[A_LO +: XLEN];
  assign dn.bus_b   = hd_q[B_LO +: XLEN];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized bench for pipe_stage_reg against a queue-based reference model.
// Also runs the directed reset, priority, kill, backpressure and flush cases.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int N_FWD = 3;

  typedef struct {
    logic [127:0] pay;
    logic [7:0]   side;
    logic         killed;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [4:0]   rs;
    logic [4:0]   rt;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  fwd_valid = '0;
  logic [14:0] fwd_wnum = '0;
  logic [95:0] fwd_data = '0;
  logic        flush = 1'b0;

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  logic rdy = 1'b0;

  pipe_stage_reg_if u_in ();
  pipe_stage_reg_if u_out ();

  pipe_stage_reg u_dut (
    .clk(clk), .rst(rst), .up(u_in), .dn(u_out),
    .fwd_valid(fwd_valid), .fwd_wnum(fwd_wnum),
    .fwd_data(fwd_data), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] byp(logic [4:0] r, logic [31:0] dflt);
    if (r == 5'd0) return dflt;
    for (int i = 0; i < N_FWD; i++)
      if (fwd_valid[i] && fwd_wnum[i*5 +: 5] == r)
        return fwd_data[i*32 +: 32];
    return dflt;
  endfunction

  task automatic model_step();
    ent_t e;
    logic acc, pop;
    if (!rst) begin
      q.delete();
      rdy = 1'b0;
      return;
    end
`ifdef PIPE_FWD_REFRESH_EN
    foreach (q[k]) begin
      q[k].a = byp(q[k].rs, q[k].a);
      q[k].b = byp(q[k].rt, q[k].b);
    end
`endif
    acc = u_in.valid && rdy;
    pop = (q.size() > 0) && u_out.ready;
    e.pay    = u_in.payload;
    e.side   = u_in.kill ? 8'h00 : u_in.side;
    e.killed = u_in.kill;
    e.a      = byp(u_in.rs, u_in.bus_a);
    e.b      = byp(u_in.rt, u_in.bus_b);
    e.rs     = u_in.rs;
    e.rt     = u_in.rt;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    rdy = (q.size() < 2);
  endtask

  task automatic compare();
    chk("in_ready", 128'(u_in.ready), 128'(rdy));
    chk("out_valid", 128'(u_out.valid), 128'(q.size() > 0));
    if (!rst) begin
      chk("rst_pay", u_out.payload, '0);
      chk("rst_side", 128'(u_out.side), '0);
      chk("rst_kill", 128'(u_out.kill), '0);
      chk("rst_a", 128'(u_out.bus_a), '0);
      chk("rst_b", 128'(u_out.bus_b), '0);
    end else if (q.size() > 0) begin
      chk("pay", u_out.payload, q[0].pay);
      chk("side", 128'(u_out.side), 128'(q[0].side));
      chk("killed", 128'(u_out.kill), 128'(q[0].killed));
      chk("bus_a", 128'(u_out.bus_a), 128'(q[0].a));
      chk("bus_b", 128'(u_out.bus_b), 128'(q[0].b));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic drive(logic v, logic [127:0] p, logic [7:0] s,
                       logic k, logic [4:0] rs, logic [4:0] rt,
                       logic [31:0] a, logic [31:0] b);
    u_in.valid   = v;
    u_in.payload = p;
    u_in.side    = s;
    u_in.kill    = k;
    u_in.rs      = rs;
    u_in.rt      = rt;
    u_in.bus_a   = a;
    u_in.bus_b   = b;
  endtask

  initial begin
    logic [31:0] held;
    drive(1'b1, 128'h1, 8'h3, 1'b0, 5'd1, 5'd2, 32'h5, 32'h6);
    u_out.ready = 1'b1;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("ready_after_rst", 128'(u_in.ready), 128'd1);

    // Bypass priority: producer 0 beats producer 1.
    drive(1'b1, 128'hA0, 8'h1, 1'b0, 5'd5, 5'd9, 32'h1111, 32'h2);
    fwd_valid = 3'b011;
    fwd_wnum  = {5'd0, 5'd5, 5'd5};
    fwd_data  = {32'h0, 32'hBBBB, 32'hAAAA};
    // consume entry accepted during the release cycle first
    u_in.valid = 1'b0;
    repeat (2) tick();
    u_in.valid = 1'b1;
    tick();
    chk("prio_a", 128'(u_out.bus_a), 128'h0000AAAA);

    // Register zero is never forwarded.
    drive(1'b1, 128'hA1, 8'h1, 1'b0, 5'd0, 5'd0, 32'h2222, 32'h3333);
    fwd_valid = 3'b001;
    fwd_wnum  = '0;
    tick();
    chk("rzero_a", 128'(u_out.bus_a), 128'h2222);

    // Kill masks side effects but keeps payload.
    fwd_valid = '0;
    drive(1'b1, 128'hDEAD_BEEF, 8'hFF, 1'b1, 5'd3, 5'd4, 32'h7, 32'h8);
    tick();
    chk("kill_side", 128'(u_out.side), '0);
    chk("kill_flag", 128'(u_out.kill), 128'd1);
    chk("kill_pay", u_out.payload, 128'hDEAD_BEEF);
    u_in.valid = 1'b0;
    tick();

    // Backpressure: four offered, two held, drained in order.
    u_out.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 128'(16'hB00 + i), 8'(i), 1'b0, 5'd0, 5'd0,
            32'(i), 32'(i));
      tick();
    end
    chk("bp_ready_low", 128'(u_in.ready), '0);
    u_in.valid  = 1'b0;
    u_out.ready = 1'b1;
    repeat (3) tick();

    // Flush while FULL with a simultaneous accept.
    u_out.ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 128'(16'hC00 + i), 8'h1, 1'b0, 5'd0, 5'd0, 32'h1, 32'h1);
      tick();
    end
    u_in.valid = 1'b1;
    flush      = 1'b1;
    tick();
    flush      = 1'b0;
    u_in.valid = 1'b0;
    chk("flush_valid", 128'(u_out.valid), '0);
    chk("flush_ready", 128'(u_in.ready), 128'd1);
    tick();

    // Held entry with rs=7 meets a later producer 2 write.
    drive(1'b1, 128'hE0, 8'h1, 1'b0, 5'd7, 5'd0, 32'h5555, 32'h0);
    tick();
    u_in.valid = 1'b0;
    fwd_valid  = 3'b100;
    fwd_wnum   = {5'd7, 5'd0, 5'd0};
    fwd_data   = {32'h1234, 64'h0};
    tick();
`ifdef PIPE_FWD_REFRESH_EN
    held = 32'h1234;
`else
    held = 32'h5555;
`endif
    chk("refresh_a", 128'(u_out.bus_a), 128'(held));
    fwd_valid   = '0;
    u_out.ready = 1'b1;
    repeat (2) tick();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom % 4) != 0,
            {$urandom, $urandom, $urandom, $urandom},
            8'($urandom), ($urandom % 8) == 0,
            5'($urandom % 8), 5'($urandom % 8),
            $urandom, $urandom);
      u_out.ready = ($urandom % 3) != 0;
      flush       = ($urandom % 40) == 0;
      fwd_valid   = 3'($urandom);
      for (int i = 0; i < N_FWD; i++) begin
        fwd_wnum[i*5 +: 5]  = 5'($urandom % 8);
        fwd_data[i*32 +: 32] = $urandom;
      end
      if (n == 1500) rst = 1'b0;
      if (n == 1503) rst = 1'b1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
